// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding and parity-type constants.
// The RX path imports the same parity constants so both ends agree on PAR_TYP.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // xor_red is the XOR-reduction of the payload; odd parity inverts it.
  function automatic logic parity_bit(input logic xor_red, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register plus bit-index counter for the UART transmitter.
// bit_o is the payload bit that belongs on the line after the coming edge.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  bit_o,
  output logic                  done_o
);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign done_o = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

  // While shifting, the line already shows shreg_q[0]; the next bit is shreg_q[1].
  assign bit_o = shift_en ? shreg_q[1] : shreg_q[0];

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit.
// One CLK cycle is one bit time; TX_OUT and Busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_out_q, tx_out_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      parity_q, parity_d;
  logic      accept;
  logic      ser_load, ser_shift, ser_bit, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (ser_load),
    .shift_en (ser_shift),
    .load_data(P_DATA),
    .bit_o    (ser_bit),
    .done_o   (ser_done)
  );

  // A new byte is taken only when the line is idle or showing the stop bit.
  assign accept = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));

  // Next-state logic; tx_out_d/busy_d describe the line after the coming edge.
  always_comb begin
    state_d   = state_q;
    tx_out_d  = 1'b1;
    busy_d    = 1'b1;
    par_en_d  = par_en_q;
    parity_d  = parity_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
      end
      START: begin
        state_d  = DATA;
        tx_out_d = ser_bit;
      end
      DATA: begin
        ser_shift = 1'b1;
        if (ser_done) begin
          state_d  = par_en_q ? PARITY : STOP;
          tx_out_d = par_en_q ? parity_q : 1'b1;
        end else begin
          tx_out_d = ser_bit;
        end
      end
      PARITY: begin
        state_d  = STOP;
        tx_out_d = 1'b1;
      end
      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d  = START;
      tx_out_d = 1'b0;
      busy_d   = 1'b1;
      ser_load = 1'b1;
      par_en_d = PAR_EN;
      parity_d = parity_bit(^P_DATA, PAR_TYP);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
    end
  end

  assign TX_OUT = tx_out_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue-of-line-bits model checked every cycle,
// plus literal frame patterns for the directed cases.
module tb_uart_tx;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  int checks = 0;
  int failures = 0;

  // Model: bits still to be put on the line, and what the line shows now.
  logic model_q[$];
  logic m_tx = 1'b1;
  logic m_busy = 1'b0;
  int   ones;
  logic pbit;

  logic [31:0] txv, busyv;

  uart_tx #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // A byte is accepted whenever no further frame bits are pending,
  // i.e. the line is idle or currently carrying a stop bit.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      model_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      if (DATA_VALID && model_q.size() == 0) begin
        model_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) model_q.push_back(P_DATA[i]);
        if (PAR_EN) begin
          ones = $countones(P_DATA);
          pbit = ((ones % 2) == 1) ? 1'b1 : 1'b0;
          if (PAR_TYP) pbit = ~pbit;
          model_q.push_back(pbit);
        end
        model_q.push_back(1'b1);
      end
      if (model_q.size() > 0) begin
        m_tx   = model_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // Every cycle out of reset, the line must match the model.
  always @(negedge CLK) begin
    if (RST) begin
      checks++;
      if (TX_OUT !== m_tx || Busy !== m_busy) begin
        failures++;
        $display("[TB] FAIL model_cmp t=%0t tx=%b busy=%b required tx=%b busy=%b",
                 $time, TX_OUT, Busy, m_tx, m_busy);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    DATA_VALID = 1'b1;
  endtask

  // Records n line cycles; at cycle holdIdx a second request is driven.
  task automatic captureLine(input int n, input int holdIdx, input logic [DW-1:0] d2,
                             input logic pen2, input logic ptyp2,
                             output logic [31:0] tv, output logic [31:0] bv);
    tv = '0;
    bv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      tv[i] = TX_OUT;
      bv[i] = Busy;
      DATA_VALID = 1'b0;
      if (i == holdIdx) applyStimulus(d2, pen2, ptyp2);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    checkOutput("reset_tx", {31'b0, TX_OUT}, 32'd1);
    checkOutput("reset_busy", {31'b0, Busy}, 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] mid-frame reset");
    applyStimulus(8'h3C, 1'b1, 1'b0);
    captureLine(3, -1, 8'h00, 1'b0, 1'b0, txv, busyv);
    checkOutput("pre_rst_tx", {31'b0, TX_OUT}, 32'd0);
    #2 RST = 1'b0;
    #1;
    checkOutput("async_rst_tx", {31'b0, TX_OUT}, 32'd1);
    checkOutput("async_rst_busy", {31'b0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] 0xA5 without parity");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    captureLine(11, -1, 8'h00, 1'b0, 1'b0, txv, busyv);
    checkOutput("a5_frame", txv, 32'h74A);
    checkOutput("a5_busy", busyv, 32'h3FF);

    $display("[TB] 0xA5 even parity");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    captureLine(12, -1, 8'h00, 1'b0, 1'b0, txv, busyv);
    checkOutput("a5_even_frame", txv, 32'hD4A);
    checkOutput("a5_even_busy", busyv, 32'h7FF);

    $display("[TB] 0xA5 odd parity");
    applyStimulus(8'hA5, 1'b1, 1'b1);
    captureLine(12, -1, 8'h00, 1'b0, 1'b0, txv, busyv);
    checkOutput("a5_odd_frame", txv, 32'hF4A);
    checkOutput("a5_odd_busy", busyv, 32'h7FF);

    $display("[TB] 0x80 even parity");
    applyStimulus(8'h80, 1'b1, 1'b0);
    captureLine(12, -1, 8'h00, 1'b0, 1'b0, txv, busyv);
    checkOutput("x80_even_frame", txv, 32'hF00);
    checkOutput("x80_even_busy", busyv, 32'h7FF);

    $display("[TB] back-to-back 0x0F then 0xF0");
    applyStimulus(8'h0F, 1'b0, 1'b0);
    captureLine(21, 9, 8'hF0, 1'b0, 1'b0, txv, busyv);
    checkOutput("b2b_frame", txv, 32'h1F821E);
    checkOutput("b2b_busy", busyv, 32'h0FFFFF);

    $display("[TB] mid-frame request ignored");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    captureLine(11, 4, 8'h5A, 1'b1, 1'b1, txv, busyv);
    checkOutput("midreq_frame", txv, 32'h74A);
    checkOutput("midreq_busy", busyv, 32'h3FF);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      if (!RST) RST = 1'b1;
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      DATA_VALID = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 RST = 1'b0;
        #1;
        checkOutput("rand_rst_tx", {31'b0, TX_OUT}, 32'd1);
        checkOutput("rand_rst_busy", {31'b0, Busy}, 32'd0);
      end
    end
    @(negedge CLK);
    RST = 1'b1;
    DATA_VALID = 1'b0;
    repeat (15) @(negedge CLK);
    checkOutput("final_idle_busy", {31'b0, Busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
